// File: rtl/fc_pkg.sv
// fc: shared Fibre Channel link types and ordered-set encodings.
//   state_t          FC_Port state reported by the receive state tracker
//   ctrl_state_t     transmit link-controller state (exposed for CSR)
//   primitive_t      primitive sequences the controller can transmit
//   encode_primitive 32-bit ordered set, K28.5 in [31:24]
package fc;

    typedef enum logic [3:0] {
        ST_AC,
        ST_LR1,
        ST_LR2,
        ST_LR3,
        ST_OL1,
        ST_OL2,
        ST_OL3,
        ST_LF1,
        ST_LF2
    } state_t;

    typedef enum logic [1:0] {
        CTRL_OFFLINE,
        CTRL_RECOVERY,
        CTRL_ACTIVE,
        CTRL_FAILURE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        PRIM_OLS,
        PRIM_NOS,
        PRIM_LR,
        PRIM_LRR,
        PRIM_IDLE
    } primitive_t;

    // Every primitive carries K28.5 in the most significant byte only.
    localparam logic [3:0] PRIM_DATAK = 4'b1000;

    function automatic logic [31:0] encode_primitive(input primitive_t p);
        logic [31:0] w;
        case (p)
            PRIM_OLS:  w = 32'hBC35_8A55; // K28.5 D21.1 D10.4 D21.2
            PRIM_NOS:  w = 32'hBC55_BF45; // K28.5 D21.2 D31.5 D5.2
            PRIM_LR:   w = 32'hBC49_BF49; // K28.5 D9.2  D31.5 D9.2
            PRIM_LRR:  w = 32'hBC35_BF49; // K28.5 D21.1 D31.5 D9.2
            default:   w = 32'hBC95_B5B5; // IDLE: K28.5 D21.4 D21.5 D21.5
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fc_link_ctrl_timer.sv
// fc_sat_timer: saturating cycle counter with threshold detect.
//   clk, reset_n  clock, asynchronous active-low reset
//   load          clear the count to 0 (takes priority over en)
//   en            advance the count by one, saturating at THRESH
//   done          count as of the end of this cycle has reached THRESH
module fc_sat_timer #(
    parameter int unsigned THRESH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned W = (THRESH < 1) ? 1 : $clog2(THRESH + 1);
    localparam logic [W-1:0] LIMIT = W'(THRESH);

    logic [W-1:0] count;
    logic [W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = '0;
        end else if (en && (count < LIMIT)) begin
            count_nxt = count + W'(1);
        end
    end

    // Looking at the updated count lets the owner act in the cycle the
    // threshold is reached, so THRESH counts whole cycles spent counting.
    assign done = !load && (count_nxt >= LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/fc_link_ctrl.sv
// fc_link_ctrl: transmit-side FC link-initialization controller.
//   clk, reset_n       word clock, asynchronous active-low reset
//   rx_state, rx_sync  receive FC_Port state and word-sync indication
//   port_enable        0 forces OFFLINE
//   tx_in_*            upstream frame words, accepted when valid && ready
//   tx_data, tx_datak  registered word stream to the 8b/10b PCS
//   link_up            controller settled in ACTIVE
//   ctrl_state         current controller state
module fc_link_ctrl
    import fc::*;
#(
    parameter int unsigned RTTOV_CYCLES   = 21_250_000,
    parameter int unsigned MIN_OLS_CYCLES = 1_062_500,
    parameter int unsigned LOS_CYCLES     = 21_250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  state_t      rx_state,
    input  logic        rx_sync,
    input  logic        port_enable,
    input  logic [31:0] tx_in_data,
    input  logic [3:0]  tx_in_datak,
    input  logic        tx_in_valid,
    output logic        tx_in_ready,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_datak,
    output logic        link_up,
    output ctrl_state_t ctrl_state
);

    ctrl_state_t state;
    ctrl_state_t nxt;
    primitive_t  prim;
    logic        ols_done;
    logic        rttov_done;
    logic        los_done;
    logic        stay_active;

    // State timers are held at 0 outside their state, so they start from 0
    // on entry.
    fc_sat_timer #(.THRESH(MIN_OLS_CYCLES)) u_ols_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != CTRL_OFFLINE),
        .en      (state == CTRL_OFFLINE),
        .done    (ols_done)
    );

    fc_sat_timer #(.THRESH(RTTOV_CYCLES)) u_rttov_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != CTRL_RECOVERY),
        .en      (state == CTRL_RECOVERY),
        .done    (rttov_done)
    );

    // Counts consecutive cycles without word sync; only consulted in ACTIVE.
    fc_sat_timer #(.THRESH(LOS_CYCLES)) u_los_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rx_sync),
        .en      (!rx_sync),
        .done    (los_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CTRL_OFFLINE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt  = state;
        prim = PRIM_IDLE;
        if (!port_enable) begin
            nxt = CTRL_OFFLINE;
        end else begin
            case (state)
                CTRL_OFFLINE: begin
                    if (ols_done) nxt = CTRL_RECOVERY;
                end
                CTRL_RECOVERY: begin
                    if (rttov_done)              nxt = CTRL_FAILURE;
                    else if (rx_state == ST_AC)  nxt = CTRL_ACTIVE;
                end
                CTRL_ACTIVE: begin
                    if (los_done)                                        nxt = CTRL_FAILURE;
                    else if ((rx_state == ST_LR2) || (rx_state == ST_OL2)) nxt = CTRL_RECOVERY;
                    else if ((rx_state == ST_LF1) || (rx_state == ST_LF2)) nxt = CTRL_FAILURE;
                end
                CTRL_FAILURE: begin
                    if (rx_state == ST_OL2) nxt = CTRL_RECOVERY;
                end
                default: nxt = CTRL_OFFLINE;
            endcase
        end

        // The registered word follows the state being entered.
        case (nxt)
            CTRL_OFFLINE: prim = PRIM_OLS;
            CTRL_FAILURE: prim = PRIM_NOS;
            CTRL_ACTIVE:  prim = PRIM_IDLE;
            default: begin
                case (rx_state)
                    ST_LR2:        prim = PRIM_LRR;
                    ST_LR3, ST_AC: prim = PRIM_IDLE;
                    default:       prim = PRIM_LR;
                endcase
            end
        endcase
    end

    // Ready asserts only after a full cycle in ACTIVE and drops on the
    // exiting edge; a word accepted on that last cycle is still emitted.
    assign stay_active = (state == CTRL_ACTIVE) && (nxt == CTRL_ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data     <= encode_primitive(PRIM_OLS);
            tx_datak    <= PRIM_DATAK;
            tx_in_ready <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            if (tx_in_valid && tx_in_ready) begin
                tx_data  <= tx_in_data;
                tx_datak <= tx_in_datak;
            end else begin
                tx_data  <= encode_primitive(prim);
                tx_datak <= PRIM_DATAK;
            end
            tx_in_ready <= stay_active;
            link_up     <= stay_active;
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_fc_link_ctrl.sv
// tb_fc_link_ctrl: scoreboard bench for fc_link_ctrl with a cycle-level
// behavioural model; directed bring-up/timer/priority phases plus random.
module tb_fc_link_ctrl;

    localparam int unsigned MIN_OLS = 8;
    localparam int unsigned RTTOV   = 64;
    localparam int unsigned LOS     = 4;

    localparam logic [31:0] W_OLS  = 32'hBC35_8A55;
    localparam logic [31:0] W_NOS  = 32'hBC55_BF45;
    localparam logic [31:0] W_LR   = 32'hBC49_BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35_BF49;
    localparam logic [31:0] W_IDLE = 32'hBC95_B5B5;

    logic            clk = 1'b0;
    logic            reset_n;
    fc::state_t      rx_state;
    logic            rx_sync;
    logic            port_enable;
    logic [31:0]     tx_in_data;
    logic [3:0]      tx_in_datak;
    logic            tx_in_valid;
    logic            tx_in_ready;
    logic [31:0]     tx_data;
    logic [3:0]      tx_datak;
    logic            link_up;
    fc::ctrl_state_t ctrl_state;

    fc_link_ctrl #(
        .RTTOV_CYCLES   (RTTOV),
        .MIN_OLS_CYCLES (MIN_OLS),
        .LOS_CYCLES     (LOS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_state    (rx_state),
        .rx_sync     (rx_sync),
        .port_enable (port_enable),
        .tx_in_data  (tx_in_data),
        .tx_in_datak (tx_in_datak),
        .tx_in_valid (tx_in_valid),
        .tx_in_ready (tx_in_ready),
        .tx_data     (tx_data),
        .tx_datak    (tx_datak),
        .link_up     (link_up),
        .ctrl_state  (ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     data;
        logic [3:0]      k;
        logic            rdy;
        logic            up;
        fc::ctrl_state_t st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: state, whole cycles spent in it, consecutive sync-low
    // run, and whether the upstream was offered ready this cycle.
    fc::ctrl_state_t m_state;
    int unsigned     m_elapsed;
    int unsigned     m_low;
    logic            m_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %h required %h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] prim_word(input fc::ctrl_state_t s, input fc::state_t rx);
        case (s)
            fc::CTRL_OFFLINE: return W_OLS;
            fc::CTRL_FAILURE: return W_NOS;
            fc::CTRL_ACTIVE:  return W_IDLE;
            default: begin
                if (rx == fc::ST_LR2) return W_LRR;
                if (rx == fc::ST_LR3 || rx == fc::ST_AC) return W_IDLE;
                return W_LR;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_state   = fc::CTRL_OFFLINE;
        m_elapsed = 0;
        m_low     = 0;
        m_ready   = 1'b0;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        exp_t            e;
        fc::ctrl_state_t n;
        int unsigned     el_now;
        int unsigned     low_now;
        el_now  = m_elapsed + 1;
        low_now = rx_sync ? 0 : m_low + 1;
        n = m_state;
        if (!port_enable) begin
            n = fc::CTRL_OFFLINE;
        end else if (m_state == fc::CTRL_OFFLINE) begin
            if (el_now >= MIN_OLS) n = fc::CTRL_RECOVERY;
        end else if (m_state == fc::CTRL_RECOVERY) begin
            if (el_now >= RTTOV) n = fc::CTRL_FAILURE;
            else if (rx_state == fc::ST_AC) n = fc::CTRL_ACTIVE;
        end else if (m_state == fc::CTRL_ACTIVE) begin
            if (low_now >= LOS) n = fc::CTRL_FAILURE;
            else if (rx_state inside {fc::ST_LR2, fc::ST_OL2}) n = fc::CTRL_RECOVERY;
            else if (rx_state inside {fc::ST_LF1, fc::ST_LF2}) n = fc::CTRL_FAILURE;
        end else begin
            if (rx_state == fc::ST_OL2) n = fc::CTRL_RECOVERY;
        end
        if (m_ready && tx_in_valid) begin
            e.data = tx_in_data;
            e.k    = tx_in_datak;
        end else begin
            e.data = prim_word(n, rx_state);
            e.k    = 4'b1000;
        end
        e.rdy = (m_state == fc::CTRL_ACTIVE) && (n == fc::CTRL_ACTIVE);
        e.up  = e.rdy;
        e.st  = n;
        exp_q.push_back(e);
        m_elapsed = (n == m_state) ? el_now : 0;
        m_low     = low_now;
        m_state   = n;
        m_ready   = e.rdy;
    endtask

    // One cycle: called just after a falling edge; returns just after the next.
    task automatic cyc(input logic en, input logic sync, input fc::state_t rx,
                       input logic v, input logic [31:0] d, input logic [3:0] k);
        port_enable = en;
        rx_sync     = sync;
        rx_state    = rx;
        tx_in_valid = v;
        tx_in_data  = d;
        tx_in_datak = k;
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic en, input fc::state_t rx);
        for (int i = 0; i < n; i++) cyc(en, 1'b1, rx, 1'b0, $urandom, 4'h0);
    endtask

    // Monitor: one expectation per rising edge, checked on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tx_data",     tx_data,              e.data);
                chk("tx_datak",    {28'h0, tx_datak},    {28'h0, e.k});
                chk("tx_in_ready", {31'h0, tx_in_ready}, {31'h0, e.rdy});
                chk("link_up",     {31'h0, link_up},     {31'h0, e.up});
                chk("ctrl_state",  {30'h0, ctrl_state},  {30'h0, e.st});
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        port_enable = 1'b1;
        rx_sync     = 1'b1;
        rx_state    = fc::ST_OL1;
        tx_in_valid = 1'b0;
        tx_in_data  = '0;
        tx_in_datak = '0;
        model_reset();
        #12;
        chk("reset tx_data",     tx_data,              W_OLS);
        chk("reset tx_datak",    {28'h0, tx_datak},    32'h8);
        chk("reset tx_in_ready", {31'h0, tx_in_ready}, 32'h0);
        chk("reset link_up",     {31'h0, link_up},     32'h0);
        chk("reset ctrl_state",  {30'h0, ctrl_state},  {30'h0, fc::CTRL_OFFLINE});
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Bring-up.
        hold(MIN_OLS, 1'b1, fc::ST_OL1);
        hold(3, 1'b1, fc::ST_LR2);
        hold(3, 1'b1, fc::ST_LR3);
        hold(3, 1'b1, fc::ST_AC);

        // Frame passthrough with random gaps.
        for (int w = 1; w <= 10; w++) begin
            while ($urandom_range(0, 2) == 0) cyc(1'b1, 1'b1, fc::ST_AC, 1'b0, $urandom, 4'h0);
            cyc(1'b1, 1'b1, fc::ST_AC, 1'b1, 32'(w), 4'h0);
        end
        hold(2, 1'b1, fc::ST_AC);

        // Loss of sync: three low cycles survive, four do not.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, fc::ST_AC, 1'b1, 32'h100 + 32'(i), 4'h0);
        cyc(1'b1, 1'b1, fc::ST_AC, 1'b1, 32'h200, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, fc::ST_AC, 1'b1, 32'h300 + 32'(i), 4'h0);
        hold(3, 1'b1, fc::ST_AC);

        // R_T_TOV expiry, then recovery from FAILURE on OL2.
        hold(1, 1'b1, fc::ST_OL2);
        hold(RTTOV + 6, 1'b1, fc::ST_OL1);
        hold(2, 1'b1, fc::ST_OL2);
        hold(3, 1'b1, fc::ST_OL1);

        // Back to ACTIVE, then port disable and LR2 together.
        hold(2, 1'b1, fc::ST_LR2);
        hold(2, 1'b1, fc::ST_LR3);
        hold(4, 1'b1, fc::ST_AC);
        cyc(1'b0, 1'b1, fc::ST_LR2, 1'b1, 32'hDEAD_0001, 4'h0);
        hold(3, 1'b0, fc::ST_LR2);

        // Random traffic with sticky rx_state.
        begin
            fc::state_t rs;
            rs = fc::ST_OL1;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 7) == 0) rs = fc::state_t'($urandom_range(0, 8));
                cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, rs,
                    $urandom_range(0, 1) == 1, $urandom, 4'($urandom));
            end
        end

        // Async reset mid-frame.
        hold(2, 1'b0, fc::ST_OL1);
        hold(MIN_OLS, 1'b1, fc::ST_OL1);
        hold(2, 1'b1, fc::ST_LR2);
        hold(2, 1'b1, fc::ST_LR3);
        hold(3, 1'b1, fc::ST_AC);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, fc::ST_AC, 1'b1, 32'hF00 + 32'(i), 4'h0);
        tx_in_valid = 1'b1;
        tx_in_data  = 32'hF0F0_F0F0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async tx_data",     tx_data,              W_OLS);
        chk("async tx_datak",    {28'h0, tx_datak},    32'h8);
        chk("async link_up",     {31'h0, link_up},     32'h0);
        chk("async tx_in_ready", {31'h0, tx_in_ready}, 32'h0);
        chk("async ctrl_state",  {30'h0, ctrl_state},  {30'h0, fc::CTRL_OFFLINE});
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        hold(MIN_OLS + 2, 1'b1, fc::ST_OL1);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_link_ctrl.md
# fc_link_ctrl

Transmit-side link-initialization controller for one FC port. Consumes the receive-side FC_Port state (`fc::state_t`) and word-sync indication, runs the FC-FS Link Reset / Offline / Link Failure protocols with their timers, and drives the 32-bit transmit word stream. Sits between the upstream frame source and the 8b/10b transmit PCS, transmitting primitive sequences when the link is not active and forwarding frame words when it is.

## Interface

Parameters:
- `RTTOV_CYCLES`, 21_250_000: R_T_TOV (100 ms at 212.5 MHz) bound on Link Recovery.
- `MIN_OLS_CYCLES`, 1_062_500: minimum OLS transmit time (5 ms) after entering Offline.
- `LOS_CYCLES`, 21_250: consecutive cycles of `rx_sync` low that declare loss of sync.

Ports:
- `clk`  in  1  transmit word clock; one clock, all logic on it.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `rx_state`  in  `fc::state_t`  FC_Port state from the receive state tracker.
- `rx_sync`  in  1  receiver word-sync valid.
- `port_enable`  in  1  CSR: 0 forces Offline.
- `tx_in_data`  in  32  upstream frame word.
- `tx_in_datak`  in  4  upstream K flags.
- `tx_in_valid`  in  1  upstream word valid.
- `tx_in_ready`  out  1  word accepted this cycle (`tx_in_valid && tx_in_ready`).
- `tx_data`  out  32  word to PCS.
- `tx_datak`  out  4  K flags to PCS.
- `link_up`  out  1  controller in ACTIVE.
- `ctrl_state`  out  `fc::ctrl_state_t`  current controller state, for CSR.

## Operation

States: OFFLINE, RECOVERY, ACTIVE, FAILURE.
- OFFLINE: transmit OLS. A counter loads 0 on entry. Once the count reaches `MIN_OLS_CYCLES` and `port_enable`=1, go to RECOVERY.
- RECOVERY: R_T_TOV counter loads 0 on entry. Transmitted primitive depends on `rx_state`:
  - LR2 → LRR.
  - LR3 → IDLE.
  - AC → IDLE, and go to ACTIVE.
  - all others → LR.
  - Counter reaching `RTTOV_CYCLES` → FAILURE.
- ACTIVE: `tx_in_ready`=1. Forward `tx_in_*` when valid, else transmit IDLE. Exits:
  - `rx_state` ∈ {LR2, OL2} → RECOVERY.
  - `rx_state` ∈ {LF1, LF2} → FAILURE.
  - Loss of sync → FAILURE.
- FAILURE: transmit NOS. `rx_state`=OL2 → RECOVERY.
- `port_enable`=0 in any state → OFFLINE (highest priority). Loss of sync is next priority, then `rx_state` exits.
- Loss of sync: a counter increments while `rx_sync`=0 and clears on `rx_sync`=1, saturating at `LOS_CYCLES`. It is evaluated in ACTIVE only.
- Leaving ACTIVE mid-frame truncates the frame. The upstream sees `tx_in_ready` drop and must abort; the controller inserts nothing.
- Ordered-set encoding comes from `fc::encode_primitive()`. `tx_datak`=4'b1000 (K28.5 in `[31:24]`) for every primitive.

## Timing

- Reset values (asynchronous): state OFFLINE, all counters 0, `tx_data`=OLS word, `tx_datak`=4'b1000, `tx_in_ready`=0, `link_up`=0.
- `tx_data`/`tx_datak` are registered: the word for cycle n reflects state and inputs sampled at edge n-1, giving 1-cycle latency from `tx_in_*`.
- `tx_in_ready` and `link_up` are registered and assert the cycle after ACTIVE is entered. They deassert in the same edge that leaves ACTIVE, so no accepted word is dropped: the word accepted on the last ACTIVE cycle is still emitted.
- Counters saturate and never wrap. Compare uses `>=`, so a parameter of 0 means immediate exit.
- Simultaneous exit conditions resolve by the priority listed above.
- `reset_n` asserted mid-frame returns to OFFLINE immediately; the output word switches to OLS asynchronously.

## Structure

- `fc` package additions:
  - `ctrl_state_t` enum (`CTRL_OFFLINE`, `CTRL_RECOVERY`, `CTRL_ACTIVE`, `CTRL_FAILURE`).
  - `encode_primitive(primitive_t)` returning the 32-bit ordered set for OLS, NOS, LR, LRR, IDLE.
- One sub-module, `fc_sat_timer` (load, enable, saturating count, `done` at threshold), instantiated three times: OLS hold, R_T_TOV, LOS.

## Test plan

Run with `MIN_OLS_CYCLES`=8, `RTTOV_CYCLES`=64, `LOS_CYCLES`=4.

- Bring-up: reset, `port_enable`=1, then drive `rx_state` OL1 → LR2 → LR3 → AC. Required: OLS for 8 cycles, then LR, then LRR, then IDLE; `link_up`=1 one cycle after AC.
- Frame passthrough: in ACTIVE, 10 valid words 0x0000_0001..0x0000_000A with datak 0. Required: same words on `tx_data` one cycle later, IDLE on gaps, `tx_in_ready`=1 throughout.
- R_T_TOV: hold `rx_state`=OL1 in RECOVERY. Required: LR for 64 cycles, then NOS. Then `rx_state`=OL2. Required: back to RECOVERY, LR.
- Loss of sync: ACTIVE mid-frame, `rx_sync`=0 for 3 cycles, then 1. Required: no exit. Then 0 for 4 cycles. Required: FAILURE, NOS, `tx_in_ready`=0, `link_up`=0.
- Priority: in ACTIVE, `port_enable`=0 and `rx_state`=LR2 on the same cycle. Required: OFFLINE, OLS.
- Async reset: assert `reset_n`=0 between clock edges during a frame. Required: `tx_data`=OLS and `link_up`=0 before the next edge.
